// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and muldiv modes shared by the sequential ALU.
package alu_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_ZERO = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_REMU = 4'b1011;
    localparam logic [3:0] ALU_ILL  = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;
    localparam logic [3:0] ALU_MUL  = 4'b1110;
    localparam logic [3:0] ALU_EQ   = 4'b1111;

    localparam logic [1:0] MD_MUL = 2'd0;
    localparam logic [1:0] MD_DIV = 2'd1;
    localparam logic [1:0] MD_REM = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIN} state_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return op == ALU_MUL || op == ALU_DIVU || op == ALU_REMU;
    endfunction

    function automatic logic [1:0] md_mode(input logic [3:0] op);
        return op == ALU_MUL ? MD_MUL : op == ALU_DIVU ? MD_DIV : MD_REM;
    endfunction
endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: one-bit-per-cycle shift-add multiplier and restoring divider.
// done is high during the cycle the last of Width steps is performed.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             done,
    output logic [Width-1:0] result
);
    localparam int CW = $clog2(Width);
    localparam logic [CW-1:0] LAST = CW'(Width - 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [Width-1:0] acc_q, acc_d, quo_q, quo_d, div_q, div_d;
    logic [Width:0]   r_sh;
    logic             ge;

    // quo_q holds the multiplier (MSB first) or the dividend shifting into the quotient;
    // a zero divisor falls out naturally as all-ones quotient and remainder = dividend
    always_comb begin
        r_sh   = {acc_q, quo_q[Width-1]};
        ge     = r_sh >= {1'b0, div_q};
        busy_d = busy_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        acc_d  = acc_q;
        quo_d  = quo_q;
        div_d  = div_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            mode_d = mode;
            acc_d  = '0;
            quo_d  = a;
            div_d  = b;
        end else if (busy_q) begin
            busy_d = cnt_q != LAST;
            cnt_d  = cnt_q + CW'(1);
            quo_d  = {quo_q[Width-2:0], mode_q != MD_MUL && ge};
            acc_d  = mode_q == MD_MUL ? (acc_q << 1) + (quo_q[Width-1] ? div_q : '0)
                   : ge ? r_sh[Width-1:0] - div_q : r_sh[Width-1:0];
        end
    end

    assign done   = busy_q && cnt_q == LAST;
    assign result = mode_q == MD_DIV ? quo_q : acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            mode_q <= MD_MUL;
            acc_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            acc_q  <= acc_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/done handshake; single-cycle ops inline,
// multiply/divide/remainder delegated to seq_muldiv.
module seq_alu
    import alu_pkg::*;
#(
    parameter int Width = 32,
    parameter int ShW   = $clog2(Width)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       Control,
    input  logic [Width-1:0] A1,
    input  logic [Width-1:0] A2,
    output logic             ready,
    output logic             done,
    output logic [Width-1:0] ALUOut,
    output logic             zero,
    output logic             illegal
);
    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [Width-1:0] a1_q, a1_d, a2_q, a2_d, alu_out_q, alu_out_d;
    logic             zero_q, zero_d, illegal_q, illegal_d, done_q, done_d;
    logic             accept, md_done;
    logic [Width-1:0] md_result, simple, result;
    logic [ShW-1:0]   sh;

    assign ready  = state_q == ST_IDLE;
    assign accept = start && ready;

    seq_muldiv #(.Width(Width)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && is_iterative(Control)),
        .mode   (md_mode(Control)),
        .a      (A1),
        .b      (A2),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        sh = a2_q[ShW-1:0];
        case (op_q)
            ALU_AND:  simple = a1_q & a2_q;
            ALU_OR:   simple = a1_q | a2_q;
            ALU_ADD:  simple = a1_q + a2_q;
            ALU_SUB:  simple = a1_q - a2_q;
            ALU_SLL:  simple = a1_q << sh;
            ALU_SRL:  simple = a1_q >> sh;
            ALU_SRA:  simple = $signed(a1_q) >>> sh;
            ALU_SLTU: simple = Width'(a1_q < a2_q);
            ALU_SLT:  simple = Width'($signed(a1_q) < $signed(a2_q));
            ALU_XOR:  simple = a1_q ^ a2_q;
            ALU_EQ:   simple = Width'(a1_q == a2_q);
            default:  simple = '0;
        endcase
        result = is_iterative(op_q) ? md_result : simple;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a1_d      = a1_q;
        a2_d      = a2_q;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                op_d    = Control;
                a1_d    = A1;
                a2_d    = A2;
                state_d = is_iterative(Control) ? ST_ITER : ST_FIN;
            end
            ST_ITER: if (md_done) state_d = ST_FIN;
            ST_FIN: begin
                state_d   = ST_IDLE;
                done_d    = 1'b1;
                alu_out_d = result;
                zero_d    = result == '0;
                illegal_d = op_q == ALU_ILL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= ALU_AND;
            a1_q      <= '0;
            a2_q      <= '0;
            alu_out_q <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign done    = done_q;
    assign ALUOut  = alu_out_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random operations on seq_alu, checked every cycle
// against a latency-countdown reference model plus hand-computed results.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  Control;
    logic [31:0] A1, A2;
    logic        ready, done, zero, illegal;
    logic [31:0] ALUOut;

    int pass_cnt = 0;
    int total_cnt = 0;

    int          m_busy = 0;
    bit          m_live = 0;
    logic [31:0] m_out, m_pend;
    logic        m_zero, m_ill, m_done, m_pend_ill;

    seq_alu dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .Control (Control),
        .A1      (A1),
        .A2      (A2),
        .ready   (ready),
        .done    (done),
        .ALUOut  (ALUOut),
        .zero    (zero),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    function automatic bit is_iter(input logic [3:0] c);
        return c == 4'hE || c == 4'hD || c == 4'hB;
    endfunction

    function automatic logic [31:0] ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh = b % 32;
        logic [63:0] p = {32'b0, a} * {32'b0, b};
        case (c)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a - b;
            4'h3: return a << sh;
            4'h8: return a >> sh;
            4'hA: return 32'($signed(a) >>> sh);
            4'h4: return {31'b0, a < b};
            4'h5: return {31'b0, $signed(a) < $signed(b)};
            4'h7: return a ^ b;
            4'hF: return {31'b0, a == b};
            4'hE: return p[31:0];
            4'hD: return b == 0 ? 32'hFFFF_FFFF : a / b;
            4'hB: return b == 0 ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // Model: after acceptance, results appear after a fixed number of further edges
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_out = 0; m_zero = 1; m_ill = 0; m_done = 0; m_live = 1;
        end else begin
            m_done = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_done = 1; m_out = m_pend; m_zero = (m_pend == 0); m_ill = m_pend_ill;
                end
            end else if (start) begin
                m_pend     = ref_op(Control, A1, A2);
                m_pend_ill = (Control == 4'hC);
                m_busy     = is_iter(Control) ? 33 : 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_ready", {31'b0, ready}, {31'b0, m_busy == 0});
            check("cyc_done", {31'b0, done}, {31'b0, m_done});
            check("cyc_aluout", ALUOut, m_out);
            check("cyc_zero", {31'b0, zero}, {31'b0, m_zero});
            check("cyc_illegal", {31'b0, illegal}, {31'b0, m_ill});
        end
    end

    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic exp_ill, input bit poke);
        int n = 1;
        bit seen = 0;
        check("ready_at_start", {31'b0, ready}, 32'd1);
        start = 1; Control = c; A1 = a; A2 = b;
        @(posedge clk); #1;
        start = 0; Control = 4'($urandom); A1 = $urandom; A2 = $urandom;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin
                if (poke) start = (n == 5);
                @(posedge clk);
                n++;
            end
        end
        start = 0;
        check("latency", n, is_iter(c) ? 34 : 2);
        check("result", ALUOut, exp);
        check("zero_flag", {31'b0, zero}, {31'b0, exp == 0});
        check("illegal_flag", {31'b0, illegal}, {31'b0, exp_ill});
        check("ready_with_done", {31'b0, ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  c;
        logic [31:0] a, b;
        bit          seen;
        reset = 1; start = 0; Control = 0; A1 = 0; A2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_aluout", ALUOut, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        check("rst_illegal", {31'b0, illegal}, 32'd0);

        run_op(4'h2, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0);
        run_op(4'h5, 32'hFFFF_FFFE, 32'd1, 32'd1, 0, 0);
        run_op(4'h4, 32'hFFFF_FFFE, 32'd1, 32'd0, 0, 0);
        run_op(4'hA, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 0, 0);
        run_op(4'hE, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F, 0, 1);
        run_op(4'hD, 32'd100, 32'd7, 32'd14, 0, 0);
        run_op(4'hB, 32'd100, 32'd7, 32'd2, 0, 0);
        run_op(4'hD, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
        run_op(4'hB, 32'd5, 32'd0, 32'd5, 0, 0);
        run_op(4'hC, 32'd9, 32'd9, 32'd0, 1, 0);
        run_op(4'h2, 32'd2, 32'd3, 32'd5, 0, 0);

        check("abort_ready", {31'b0, ready}, 32'd1);
        start = 1; Control = 4'hD; A1 = 32'd1000; A2 = 32'd3;
        @(posedge clk); #1;
        start = 0;
        repeat (9) @(posedge clk);
        @(negedge clk) reset = 1;
        @(posedge clk);
        @(negedge clk) reset = 0;
        check("abort_ready_after", {31'b0, ready}, 32'd1);
        check("abort_aluout", ALUOut, 32'd0);
        check("abort_zero", {31'b0, zero}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort_no_done", {31'b0, seen}, 32'd0);
        run_op(4'h6, 32'd10, 32'd12, 32'hFFFF_FFFE, 0, 0);

        for (int i = 0; i < 60; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op(c, a, b, ref_op(c, a, b), c == 4'hC, i % 7 == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
